// File: rtl/s2p_pkg.sv
// s2p_pkg: shared state encoding and defaults for the serial frame receiver
package s2p_pkg;
  localparam int S2P_WIDTH_DEFAULT = 8;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, RESYNC} state_e;
endpackage

// File: rtl/s2p_shift_reg.sv
// s2p_shift_reg: MSB-first serial-to-parallel shift register with synchronous clear
module s2p_shift_reg
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;
  // first bit shifted in ends up in the MSB after WIDTH shifts
  always_ff @(posedge clk or negedge reset)
    if (!reset) q_q <= '0;
    else if (clr_i) q_q <= '0;
    else if (en_i) q_q <= {q_q[WIDTH-2:0], d_i};
  assign q_o = q_q;
endmodule

// File: rtl/s2p_frame_ctrl.sv
// s2p_frame_ctrl: framed serial receiver with even parity, stop check and one-entry output buffer
module s2p_frame_ctrl
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d, sr;
  logic             par_q, par_d, valid_q, valid_d, busy_q, busy_d;
  logic             perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic             clr, shift;

  s2p_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk  (clk),
    .reset(reset),
    .clr_i(clr),
    .en_i (shift),
    .d_i  (serial_in),
    .q_o  (sr)
  );

  // state, counter, parity accumulator and registered outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end

  // frame sequencing on bit_en; the consumer handshake runs every cycle regardless
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q & ~data_ready;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    clr     = 1'b0;
    shift   = 1'b0;
    if (bit_en)
      case (state_q)
        IDLE: if (!serial_in) begin
          state_d = DATA;
          cnt_d   = '0;
          par_d   = 1'b0;
          clr     = 1'b1;
        end
        DATA: begin
          shift   = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          par_d   = par_q ^ serial_in;
          state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = par_q ^ serial_in;
          state_d = STOP;
        end
        STOP: if (!serial_in) begin
          ferr_d  = 1'b1;
          state_d = RESYNC;
        end else begin
          state_d = IDLE;
          if (par_q) perr_d = 1'b1;
          else if (valid_q && !data_ready) ovr_d = 1'b1;
          else begin
            data_d  = sr;
            valid_d = 1'b1;
          end
        end
        RESYNC: state_d = serial_in ? IDLE : RESYNC;
        default: state_d = IDLE;
      endcase
    busy_d = state_d != IDLE;
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
endmodule
